// File: rtl/tsmap_port_arbiter_pkg.sv
// Shared types for the TS map port arbiter: request sources, response tags,
// round-robin pointer encoding and the common address/data widths.
package tsmap_port_arbiter_pkg;

  localparam int TsmapAddrW = 16;
  localparam int TsmapDataW = 32;

  typedef enum logic [1:0] {
    SRC_CORE = 2'd0,
    SRC_RVK  = 2'd1,
    SRC_SW   = 2'd2
  } tsmap_src_e;

  typedef enum logic {
    RR_RVK = 1'b0,
    RR_SW  = 1'b1
  } tsmap_rr_e;

  typedef struct packed {
    logic       valid;
    tsmap_src_e src;
    logic       err;
    logic       is_write;
  } tsmap_tag_t;

  function automatic logic tsmap_in_range(input logic [TsmapAddrW-1:0] addr,
                                          input int unsigned           size);
    return 32'(addr) < size;
  endfunction

endpackage

// File: rtl/tsmap_resp_pipe.sv
// Tag/data return pipeline: one stage aligned with the RAM read latency,
// plus an optional output register stage.
module tsmap_resp_pipe
  import tsmap_port_arbiter_pkg::*;
#(
  parameter bit OutReg = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  tsmap_tag_t            tag_i,
  input  logic [TsmapDataW-1:0] ram_rdata_i,
  output tsmap_tag_t            tag_o,
  output logic [TsmapDataW-1:0] rdata_o
);

  tsmap_tag_t            tag1_q;
  logic [TsmapDataW-1:0] data1;
  tsmap_tag_t            tagStage;
  logic [TsmapDataW-1:0] dataStage;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag1_q <= '0;
    end else begin
      tag1_q <= tag_i;
    end
  end

  // RAM data only belongs to an in-range read; everything else returns zero.
  assign data1 = (tag1_q.valid && !tag1_q.err && !tag1_q.is_write) ? ram_rdata_i : '0;

  generate
    if (OutReg) begin : g_out_reg
      tsmap_tag_t            tag2_q;
      logic [TsmapDataW-1:0] data2_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          tag2_q  <= '0;
          data2_q <= '0;
        end else begin
          tag2_q  <= tag1_q;
          data2_q <= data1;
        end
      end

      assign tagStage  = tag2_q;
      assign dataStage = data2_q;
    end else begin : g_no_reg
      assign tagStage  = tag1_q;
      assign dataStage = data1;
    end
  endgenerate

  // Responses are suppressed while reset is held so in-flight accesses vanish.
  always_comb begin
    tag_o   = tagStage;
    rdata_o = dataStage;
    if (rst_i) begin
      tag_o   = '0;
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/tsmap_port_arbiter.sv
// Shares the single-port TS map SRAM between the core load filter, the
// revocation engine and a software maintenance port.
module tsmap_port_arbiter
  import tsmap_port_arbiter_pkg::*;
#(
  parameter int unsigned TSMapSize   = 1024,
  parameter bit          OutReg      = 1'b0,
  parameter int unsigned StarveLimit = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  core_cs_i,
  input  logic [TsmapAddrW-1:0] core_addr_i,
  output logic                  core_rvalid_o,
  output logic [TsmapDataW-1:0] core_rdata_o,

  input  logic                  rvk_req_i,
  input  logic [TsmapAddrW-1:0] rvk_addr_i,
  output logic                  rvk_gnt_o,
  output logic                  rvk_rvalid_o,
  output logic [TsmapDataW-1:0] rvk_rdata_o,
  output logic                  rvk_err_o,

  input  logic                  sw_req_i,
  input  logic                  sw_we_i,
  input  logic [3:0]            sw_be_i,
  input  logic [TsmapAddrW-1:0] sw_addr_i,
  input  logic [TsmapDataW-1:0] sw_wdata_i,
  output logic                  sw_gnt_o,
  output logic                  sw_rvalid_o,
  output logic [TsmapDataW-1:0] sw_rdata_o,
  output logic                  sw_err_o,

  output logic                  tsmap_cs_o,
  output logic                  tsmap_we_o,
  output logic [3:0]            tsmap_be_o,
  output logic [TsmapAddrW-1:0] tsmap_addr_o,
  output logic [TsmapDataW-1:0] tsmap_wdata_o,
  input  logic [TsmapDataW-1:0] tsmap_rdata_i,

  output logic                  starve_o
);

  localparam logic [7:0] StarveLim = 8'(StarveLimit);

  tsmap_rr_e             rrPtr_q, rrPtr_d;
  logic [7:0]            rvkCnt_q, rvkCnt_d;
  logic [7:0]            swCnt_q, swCnt_d;
  logic                  starve_q, starve_d;

  logic                  coreGnt, rvkGnt, swGnt, secFree;
  logic                  anyGnt, selWe, selInRange, issue;
  logic [3:0]            selBe;
  logic [TsmapAddrW-1:0] selAddr;
  logic [TsmapDataW-1:0] selWdata;
  tsmap_src_e            selSrc;
  tsmap_tag_t            reqTag, respTag;
  logic [TsmapDataW-1:0] respData;
  logic                  coreSel, rvkSel, swSel;

  // Core always wins; the secondaries share the remaining cycles round-robin.
  assign coreGnt = core_cs_i && !rst_i;
  assign secFree = !rst_i && !core_cs_i;
  assign rvkGnt  = secFree && rvk_req_i && (!sw_req_i || (rrPtr_q == RR_RVK));
  assign swGnt   = secFree && sw_req_i && (!rvk_req_i || (rrPtr_q == RR_SW));

  assign rvk_gnt_o = rvkGnt;
  assign sw_gnt_o  = swGnt;

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (rvkGnt) begin
      rrPtr_d = RR_SW;
    end else if (swGnt) begin
      rrPtr_d = RR_RVK;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rrPtr_q <= RR_RVK;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

  always_comb begin
    anyGnt   = 1'b0;
    selWe    = 1'b0;
    selBe    = '0;
    selAddr  = '0;
    selWdata = '0;
    selSrc   = SRC_CORE;
    if (coreGnt) begin
      anyGnt  = 1'b1;
      selBe   = 4'hF;
      selAddr = core_addr_i;
      selSrc  = SRC_CORE;
    end else if (rvkGnt) begin
      anyGnt  = 1'b1;
      selBe   = 4'hF;
      selAddr = rvk_addr_i;
      selSrc  = SRC_RVK;
    end else if (swGnt) begin
      anyGnt   = 1'b1;
      selWe    = sw_we_i;
      selBe    = sw_be_i;
      selAddr  = sw_addr_i;
      selWdata = sw_wdata_i;
      selSrc   = SRC_SW;
    end
  end

  // Out-of-range accesses are granted but never reach the RAM.
  assign selInRange = tsmap_in_range(selAddr, TSMapSize);
  assign issue      = anyGnt && selInRange;

  assign tsmap_cs_o    = issue;
  assign tsmap_we_o    = issue && selWe;
  assign tsmap_be_o    = issue ? selBe : '0;
  assign tsmap_addr_o  = issue ? selAddr : '0;
  assign tsmap_wdata_o = issue ? selWdata : '0;

  always_comb begin
    reqTag          = '0;
    reqTag.valid    = anyGnt;
    reqTag.src      = selSrc;
    reqTag.err      = anyGnt && !selInRange;
    reqTag.is_write = anyGnt && selWe;
  end

  tsmap_resp_pipe #(
    .OutReg(OutReg)
  ) u_resp_pipe (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tag_i      (reqTag),
    .ram_rdata_i(tsmap_rdata_i),
    .tag_o      (respTag),
    .rdata_o    (respData)
  );

  assign coreSel = respTag.valid && (respTag.src == SRC_CORE);
  assign rvkSel  = respTag.valid && (respTag.src == SRC_RVK);
  assign swSel   = respTag.valid && (respTag.src == SRC_SW);

  assign core_rvalid_o = coreSel;
  assign core_rdata_o  = coreSel ? respData : '0;
  assign rvk_rvalid_o  = rvkSel;
  assign rvk_rdata_o   = rvkSel ? respData : '0;
  assign rvk_err_o     = rvkSel && respTag.err;
  assign sw_rvalid_o   = swSel;
  assign sw_rdata_o    = (swSel && !respTag.is_write) ? respData : '0;
  assign sw_err_o      = swSel && respTag.err;

  // Denied-cycle counters saturate; the flag latches until reset.
  always_comb begin
    rvkCnt_d = '0;
    swCnt_d  = '0;
    if (rvk_req_i && !rvkGnt) begin
      rvkCnt_d = (rvkCnt_q == 8'hFF) ? rvkCnt_q : rvkCnt_q + 8'd1;
    end
    if (sw_req_i && !swGnt) begin
      swCnt_d = (swCnt_q == 8'hFF) ? swCnt_q : swCnt_q + 8'd1;
    end
    starve_d = starve_q || (rvkCnt_d >= StarveLim) || (swCnt_d >= StarveLim);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvkCnt_q <= '0;
      swCnt_q  <= '0;
      starve_q <= 1'b0;
    end else begin
      rvkCnt_q <= rvkCnt_d;
      swCnt_q  <= swCnt_d;
      starve_q <= starve_d;
    end
  end

  assign starve_o = starve_q;

endmodule

// File: tb/tb_tsmap_port_arbiter.sv
// Directed bench for tsmap_port_arbiter: two instances (OutReg=0 and 1) share
// stimulus, each backed by its own behavioural single-port RAM.
module tb_tsmap_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        coreCs;
  logic [15:0] coreAddr;
  logic        rvkReq;
  logic [15:0] rvkAddr;
  logic        swReq;
  logic        swWe;
  logic [3:0]  swBe;
  logic [15:0] swAddr;
  logic [31:0] swWdata;

  logic        d0CoreRvalid, d0RvkGnt, d0RvkRvalid, d0RvkErr, d0SwGnt, d0SwRvalid, d0SwErr;
  logic [31:0] d0CoreRdata, d0RvkRdata, d0SwRdata;
  logic        d0Cs, d0We, d0Starve;
  logic [3:0]  d0Be;
  logic [15:0] d0Addr;
  logic [31:0] d0Wdata;
  logic [31:0] ram0Rdata = '0;

  logic        d1CoreRvalid, d1RvkGnt, d1RvkRvalid, d1RvkErr, d1SwGnt, d1SwRvalid, d1SwErr;
  logic [31:0] d1CoreRdata, d1RvkRdata, d1SwRdata;
  logic        d1Cs, d1We, d1Starve;
  logic [3:0]  d1Be;
  logic [15:0] d1Addr;
  logic [31:0] d1Wdata;
  logic [31:0] ram1Rdata = '0;

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];

  int checks = 0;
  int errors = 0;

  tsmap_port_arbiter #(.TSMapSize(1024), .OutReg(1'b0), .StarveLimit(16)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .core_cs_i(coreCs), .core_addr_i(coreAddr),
    .core_rvalid_o(d0CoreRvalid), .core_rdata_o(d0CoreRdata),
    .rvk_req_i(rvkReq), .rvk_addr_i(rvkAddr), .rvk_gnt_o(d0RvkGnt),
    .rvk_rvalid_o(d0RvkRvalid), .rvk_rdata_o(d0RvkRdata), .rvk_err_o(d0RvkErr),
    .sw_req_i(swReq), .sw_we_i(swWe), .sw_be_i(swBe), .sw_addr_i(swAddr),
    .sw_wdata_i(swWdata), .sw_gnt_o(d0SwGnt), .sw_rvalid_o(d0SwRvalid),
    .sw_rdata_o(d0SwRdata), .sw_err_o(d0SwErr),
    .tsmap_cs_o(d0Cs), .tsmap_we_o(d0We), .tsmap_be_o(d0Be), .tsmap_addr_o(d0Addr),
    .tsmap_wdata_o(d0Wdata), .tsmap_rdata_i(ram0Rdata),
    .starve_o(d0Starve)
  );

  tsmap_port_arbiter #(.TSMapSize(1024), .OutReg(1'b1), .StarveLimit(16)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .core_cs_i(coreCs), .core_addr_i(coreAddr),
    .core_rvalid_o(d1CoreRvalid), .core_rdata_o(d1CoreRdata),
    .rvk_req_i(rvkReq), .rvk_addr_i(rvkAddr), .rvk_gnt_o(d1RvkGnt),
    .rvk_rvalid_o(d1RvkRvalid), .rvk_rdata_o(d1RvkRdata), .rvk_err_o(d1RvkErr),
    .sw_req_i(swReq), .sw_we_i(swWe), .sw_be_i(swBe), .sw_addr_i(swAddr),
    .sw_wdata_i(swWdata), .sw_gnt_o(d1SwGnt), .sw_rvalid_o(d1SwRvalid),
    .sw_rdata_o(d1SwRdata), .sw_err_o(d1SwErr),
    .tsmap_cs_o(d1Cs), .tsmap_we_o(d1We), .tsmap_be_o(d1Be), .tsmap_addr_o(d1Addr),
    .tsmap_wdata_o(d1Wdata), .tsmap_rdata_i(ram1Rdata),
    .starve_o(d1Starve)
  );

  function automatic logic [31:0] beMask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Behavioural single-port RAMs: read data appears one cycle after cs.
  always @(posedge clk) begin
    if (d0Cs) begin
      if (d0We) mem0[d0Addr[9:0]] <= (mem0[d0Addr[9:0]] & ~beMask(d0Be)) | (d0Wdata & beMask(d0Be));
      else      ram0Rdata <= mem0[d0Addr[9:0]];
    end
  end

  always @(posedge clk) begin
    if (d1Cs) begin
      if (d1We) mem1[d1Addr[9:0]] <= (mem1[d1Addr[9:0]] & ~beMask(d1Be)) | (d1Wdata & beMask(d1Be));
      else      ram1Rdata <= mem1[d1Addr[9:0]];
    end
  end

  task automatic applyStimulus(input logic cs, input logic [15:0] ca,
                               input logic rr, input logic [15:0] ra,
                               input logic sr, input logic swe, input logic [3:0] sbe,
                               input logic [15:0] sa, input logic [31:0] swd);
    coreCs   = cs;
    coreAddr = ca;
    rvkReq   = rr;
    rvkAddr  = ra;
    swReq    = sr;
    swWe     = swe;
    swBe     = sbe;
    swAddr   = sa;
    swWdata  = swd;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", name, observed, expected);
    end
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    mem0[16'h010] = 32'hA5A5_0001; mem1[16'h010] = 32'hA5A5_0001;
    mem0[16'h020] = 32'h0000_00FF; mem1[16'h020] = 32'h0000_00FF;
    mem0[16'h005] = 32'hFFFF_FFFF; mem1[16'h005] = 32'hFFFF_FFFF;

    rst = 1'b1;
    applyIdle();
    repeat (3) nextCycle();
    checkOutput("reset_core_rvalid", 32'(d0CoreRvalid), 32'd0);
    checkOutput("reset_rvk_gnt", 32'(d0RvkGnt), 32'd0);
    checkOutput("reset_tsmap_cs", 32'(d0Cs), 32'd0);
    checkOutput("reset_starve", 32'(d0Starve), 32'd0);
    checkOutput("reset_d1_sw_rvalid", 32'(d1SwRvalid), 32'd0);
    rst = 1'b0;

    // Round-robin: both secondaries request continuously, revoker first.
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h020, 1'b1, 1'b0, 4'hF, 16'h010, 32'h0);
    checkOutput("rr_a_rvk_gnt", 32'(d0RvkGnt), 32'd1);
    checkOutput("rr_a_sw_gnt", 32'(d0SwGnt), 32'd0);
    checkOutput("rr_a_tsmap_addr", 32'(d0Addr), 32'h020);
    nextCycle();
    checkOutput("rr_b_sw_gnt", 32'(d0SwGnt), 32'd1);
    checkOutput("rr_b_rvk_gnt", 32'(d0RvkGnt), 32'd0);
    checkOutput("rr_b_tsmap_addr", 32'(d0Addr), 32'h010);
    checkOutput("rr_b_rvk_rvalid", 32'(d0RvkRvalid), 32'd1);
    checkOutput("rr_b_rvk_rdata", d0RvkRdata, 32'h0000_00FF);
    nextCycle();
    checkOutput("rr_c_rvk_gnt", 32'(d0RvkGnt), 32'd1);
    checkOutput("rr_c_sw_rvalid", 32'(d0SwRvalid), 32'd1);
    checkOutput("rr_c_sw_rdata", d0SwRdata, 32'hA5A5_0001);
    checkOutput("rr_c_d1_rvk_rvalid", 32'(d1RvkRvalid), 32'd1);
    checkOutput("rr_c_d1_rvk_rdata", d1RvkRdata, 32'h0000_00FF);
    nextCycle();
    checkOutput("rr_d_sw_gnt", 32'(d0SwGnt), 32'd1);
    nextCycle();
    applyIdle();
    checkOutput("rr_e_sw_rvalid", 32'(d0SwRvalid), 32'd1);
    checkOutput("rr_e_tsmap_cs", 32'(d0Cs), 32'd0);
    nextCycle();
    checkOutput("rr_f_sw_rvalid", 32'(d0SwRvalid), 32'd0);
    checkOutput("rr_f_d1_sw_rvalid", 32'(d1SwRvalid), 32'd1);
    nextCycle();

    // Core vs revoker conflict.
    applyStimulus(1'b1, 16'h010, 1'b1, 16'h020, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    checkOutput("cf0_rvk_gnt", 32'(d0RvkGnt), 32'd0);
    checkOutput("cf0_tsmap_cs", 32'(d0Cs), 32'd1);
    checkOutput("cf0_tsmap_addr", 32'(d0Addr), 32'h010);
    nextCycle();
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h020, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    checkOutput("cf1_core_rvalid", 32'(d0CoreRvalid), 32'd1);
    checkOutput("cf1_core_rdata", d0CoreRdata, 32'hA5A5_0001);
    checkOutput("cf1_rvk_gnt", 32'(d0RvkGnt), 32'd1);
    checkOutput("cf1_tsmap_addr", 32'(d0Addr), 32'h020);
    checkOutput("cf1_d1_core_rvalid", 32'(d1CoreRvalid), 32'd0);
    nextCycle();
    applyIdle();
    checkOutput("cf2_rvk_rvalid", 32'(d0RvkRvalid), 32'd1);
    checkOutput("cf2_rvk_rdata", d0RvkRdata, 32'h0000_00FF);
    checkOutput("cf2_rvk_err", 32'(d0RvkErr), 32'd0);
    checkOutput("cf2_core_rvalid", 32'(d0CoreRvalid), 32'd0);
    checkOutput("cf2_d1_core_rvalid", 32'(d1CoreRvalid), 32'd1);
    checkOutput("cf2_d1_core_rdata", d1CoreRdata, 32'hA5A5_0001);
    nextCycle();
    checkOutput("cf3_d1_rvk_rvalid", 32'(d1RvkRvalid), 32'd1);
    checkOutput("cf3_d1_rvk_rdata", d1RvkRdata, 32'h0000_00FF);
    checkOutput("cf3_rvk_rvalid", 32'(d0RvkRvalid), 32'd0);
    nextCycle();

    // Software partial write followed by read-back.
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 4'b0010, 16'h005, 32'h0000_AB00);
    checkOutput("wr_sw_gnt", 32'(d0SwGnt), 32'd1);
    checkOutput("wr_tsmap_we", 32'(d0We), 32'd1);
    checkOutput("wr_tsmap_be", 32'(d0Be), 32'h2);
    checkOutput("wr_tsmap_wdata", d0Wdata, 32'h0000_AB00);
    nextCycle();
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 4'hF, 16'h005, 32'h0);
    checkOutput("rd_sw_gnt", 32'(d0SwGnt), 32'd1);
    checkOutput("rd_tsmap_we", 32'(d0We), 32'd0);
    checkOutput("wr_sw_rvalid", 32'(d0SwRvalid), 32'd1);
    checkOutput("wr_sw_rdata", d0SwRdata, 32'h0);
    nextCycle();
    applyIdle();
    checkOutput("rd_sw_rvalid", 32'(d0SwRvalid), 32'd1);
    checkOutput("rd_sw_rdata", d0SwRdata, 32'hFFFF_ABFF);
    checkOutput("rd_sw_err", 32'(d0SwErr), 32'd0);
    checkOutput("wr_d1_sw_rvalid", 32'(d1SwRvalid), 32'd1);
    checkOutput("wr_d1_sw_rdata", d1SwRdata, 32'h0);
    nextCycle();
    checkOutput("rd_d1_sw_rdata", d1SwRdata, 32'hFFFF_ABFF);
    nextCycle();

    // Out-of-range revoker read.
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h0400, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    checkOutput("oor_rvk_gnt", 32'(d0RvkGnt), 32'd1);
    checkOutput("oor_tsmap_cs", 32'(d0Cs), 32'd0);
    checkOutput("oor_tsmap_addr", 32'(d0Addr), 32'h0);
    nextCycle();
    applyIdle();
    checkOutput("oor_rvk_rvalid", 32'(d0RvkRvalid), 32'd1);
    checkOutput("oor_rvk_err", 32'(d0RvkErr), 32'd1);
    checkOutput("oor_rvk_rdata", d0RvkRdata, 32'h0);
    nextCycle();
    checkOutput("oor_d1_rvk_err", 32'(d1RvkErr), 32'd1);
    checkOutput("oor_rvk_err_done", 32'(d0RvkErr), 32'd0);
    nextCycle();

    // Out-of-range core read returns zero data.
    applyStimulus(1'b1, 16'h0800, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    checkOutput("core_oor_tsmap_cs", 32'(d0Cs), 32'd0);
    nextCycle();
    applyIdle();
    checkOutput("core_oor_rvalid", 32'(d0CoreRvalid), 32'd1);
    checkOutput("core_oor_rdata", d0CoreRdata, 32'h0);
    nextCycle();

    // Starvation: core occupies the RAM while software keeps requesting.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 16'h010, 1'b0, 16'h0, 1'b1, 1'b0, 4'hF, 16'h020, 32'h0);
      if (k == 0)  checkOutput("stv_sw_gnt_denied", 32'(d0SwGnt), 32'd0);
      if (k == 3)  checkOutput("stv_d1_core_rvalid", 32'(d1CoreRvalid), 32'd1);
      if (k == 15) checkOutput("stv_starve_k15", 32'(d0Starve), 32'd0);
      if (k == 16) checkOutput("stv_starve_k16", 32'(d0Starve), 32'd1);
      if (k == 16) checkOutput("stv_d1_starve_k16", 32'(d1Starve), 32'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 4'hF, 16'h020, 32'h0);
    checkOutput("stv_sw_gnt_after", 32'(d0SwGnt), 32'd1);
    nextCycle();
    applyIdle();
    checkOutput("stv_sw_rvalid", 32'(d0SwRvalid), 32'd1);
    checkOutput("stv_sw_rdata", d0SwRdata, 32'h0000_00FF);
    repeat (3) nextCycle();
    checkOutput("stv_starve_sticky", 32'(d0Starve), 32'd1);
    checkOutput("stv_d1_starve_sticky", 32'(d1Starve), 32'd1);

    // Reset asserted the cycle after a core read.
    applyStimulus(1'b1, 16'h010, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    nextCycle();
    rst = 1'b1;
    applyIdle();
    checkOutput("rstmf_core_rvalid", 32'(d0CoreRvalid), 32'd0);
    checkOutput("rstmf_core_rdata", d0CoreRdata, 32'h0);
    nextCycle();
    rst = 1'b0;
    applyIdle();
    checkOutput("rstmf_d1_core_rvalid", 32'(d1CoreRvalid), 32'd0);
    checkOutput("rstmf_starve", 32'(d0Starve), 32'd0);
    checkOutput("rstmf_d1_starve", 32'(d1Starve), 32'd0);
    checkOutput("rstmf_tsmap_cs", 32'(d0Cs), 32'd0);
    nextCycle();
    checkOutput("rstmf_d1_core_rvalid_late", 32'(d1CoreRvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
